// File: rtl/ysyx_25020037_axi_master_if.sv
// ysyx_25020037_axi_master_if: single-beat AXI4 bus between the master bridge and the fabric
interface ysyx_25020037_axi_master_if;
   logic        awvalid;
   logic        awready;
   logic [31:0] awaddr;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        wvalid;
   logic        wready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;
   logic        arvalid;
   logic        arready;
   logic [31:0] araddr;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        rvalid;
   logic        rready;
   logic [1:0]  rresp;
   logic [31:0] rdata;
   logic        rlast;
   logic [3:0]  rid;

   modport master (
      output awvalid, awaddr, awid, awlen, awsize, awburst,
      output wvalid, wdata, wstrb, wlast, bready,
      output arvalid, araddr, arid, arlen, arsize, arburst, rready,
      input  awready, wready, bvalid, bresp, bid,
      input  arready, rvalid, rresp, rdata, rlast, rid
   );

   modport slave (
      input  awvalid, awaddr, awid, awlen, awsize, awburst,
      input  wvalid, wdata, wstrb, wlast, bready,
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
      output awready, wready, bvalid, bresp, bid,
      output arready, rvalid, rresp, rdata, rlast, rid
   );
endinterface

// File: rtl/ysyx_25020037_axi_master.sv
// ysyx_25020037_axi_master: single-outstanding core-request to AXI4 single-beat bridge.
// Optional watchdog enabled by defining YSYX_25020037_AXI_TIMEOUT_EN.
module ysyx_25020037_axi_master #(
   parameter logic [3:0] AXI_ID         = 4'h0,
   parameter int         TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [31:0] i_req_addr,
   input  logic [2:0]  i_req_size,
   input  logic [31:0] i_req_wdata,
   input  logic [3:0]  i_req_wstrb,
   output logic        o_resp_valid,
   input  logic        i_resp_ready,
   output logic [31:0] o_resp_rdata,
   output logic        o_resp_err,
   ysyx_25020037_axi_master_if.master axi
);
   typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP, S_RESP} state_t;

   state_t      r_state;
   logic        r_req_ready;
   logic        r_resp_valid;
   logic        r_err;
   logic [31:0] r_rdata;
   logic [31:0] r_addr;
   logic [2:0]  r_size;
   logic [31:0] r_wdata;
   logic [3:0]  r_wstrb;
   logic        r_arvalid;
   logic        r_rready;
   logic        r_awvalid;
   logic        r_wvalid;
   logic        r_bready;
   logic        r_aw_done;
   logic        r_w_done;
   logic        w_aw_ok;
   logic        w_w_ok;

   // a channel counts as done if it finished earlier or handshakes this cycle
   assign w_aw_ok = r_aw_done | (r_awvalid & axi.awready);
   assign w_w_ok  = r_w_done | (r_wvalid & axi.wready);

`ifdef YSYX_25020037_AXI_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        w_busy;
   assign w_busy = (r_state == S_RADDR) | (r_state == S_RDATA) | (r_state == S_WREQ) | (r_state == S_WRESP);
`else
   logic w_unused_timeout;
   assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

   // transaction FSM; every handshake output is a register driven from here
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_req_ready  <= 1'b1;
         r_resp_valid <= 1'b0;
         r_err        <= 1'b0;
         r_rdata      <= 32'd0;
         r_addr       <= 32'd0;
         r_size       <= 3'd0;
         r_wdata      <= 32'd0;
         r_wstrb      <= 4'd0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_awvalid    <= 1'b0;
         r_wvalid     <= 1'b0;
         r_bready     <= 1'b0;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
`ifdef YSYX_25020037_AXI_TIMEOUT_EN
         r_cnt        <= 16'd0;
`endif
      end else begin
         case (r_state)
            S_IDLE: if (i_req_valid) begin
               r_req_ready <= 1'b0;
               r_addr      <= i_req_addr;
               r_size      <= i_req_size;
               r_wdata     <= i_req_wdata << {i_req_addr[1:0], 3'b000};
               r_wstrb     <= i_req_wstrb << i_req_addr[1:0];
               r_aw_done   <= 1'b0;
               r_w_done    <= 1'b0;
               r_arvalid   <= ~i_req_we;
               r_awvalid   <= i_req_we;
               r_wvalid    <= i_req_we;
               r_state     <= i_req_we ? S_WREQ : S_RADDR;
            end
            S_RADDR: if (axi.arready) begin
               r_arvalid <= 1'b0;
               r_rready  <= 1'b1;
               r_state   <= S_RDATA;
            end
            S_RDATA: if (axi.rvalid) begin
               r_rready     <= 1'b0;
               r_rdata      <= axi.rdata >> {r_addr[1:0], 3'b000};
               r_err        <= (axi.rresp != 2'b00) | (axi.rid != AXI_ID) | ~axi.rlast;
               r_resp_valid <= 1'b1;
               r_state      <= S_RESP;
            end
            S_WREQ: begin
               if (r_awvalid & axi.awready) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (r_wvalid & axi.wready) begin
                  r_wvalid <= 1'b0;
                  r_w_done <= 1'b1;
               end
               if (w_aw_ok & w_w_ok) begin
                  r_bready <= 1'b1;
                  r_state  <= S_WRESP;
               end
            end
            S_WRESP: if (axi.bvalid) begin
               r_bready     <= 1'b0;
               r_rdata      <= 32'd0;
               r_err        <= (axi.bresp != 2'b00) | (axi.bid != AXI_ID);
               r_resp_valid <= 1'b1;
               r_state      <= S_RESP;
            end
            S_RESP: if (i_resp_ready) begin
               r_resp_valid <= 1'b0;
               r_req_ready  <= 1'b1;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
`ifdef YSYX_25020037_AXI_TIMEOUT_EN
         r_cnt <= (r_state == S_IDLE) ? 16'd0 : (w_busy ? r_cnt + 16'd1 : r_cnt);
         if (w_busy && r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_rdata      <= 32'hDEAD_BEEF;
            r_err        <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= S_RESP;
`ifndef SYNTHESIS
            $display("axi_master: timeout at address %h", r_addr);
`endif
         end
`endif
      end
   end

   assign o_req_ready  = r_req_ready;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_rdata = r_rdata;
   assign o_resp_err   = r_err;

   assign axi.arvalid = r_arvalid;
   assign axi.araddr  = r_addr;
   assign axi.arid    = AXI_ID;
   assign axi.arlen   = 8'd0;
   assign axi.arsize  = r_size;
   assign axi.arburst = 2'b01;
   assign axi.rready  = r_rready;
   assign axi.awvalid = r_awvalid;
   assign axi.awaddr  = r_addr;
   assign axi.awid    = AXI_ID;
   assign axi.awlen   = 8'd0;
   assign axi.awsize  = r_size;
   assign axi.awburst = 2'b01;
   assign axi.wvalid  = r_wvalid;
   assign axi.wdata   = r_wdata;
   assign axi.wstrb   = r_wstrb;
   assign axi.wlast   = 1'b1;
   assign axi.bready  = r_bready;
endmodule

// File: tb/tb_ysyx_25020037_axi_master.sv
// tb_ysyx_25020037_axi_master: directed and randomized bench with an in-bench AXI responder and lane model
module tb_ysyx_25020037_axi_master;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [31:0] req_addr = 32'd0;
   logic [2:0]  req_size = 3'd0;
   logic [31:0] req_wdata = 32'd0;
   logic [3:0]  req_wstrb = 4'd0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_rdata;
   logic        resp_err;
   int          n_checks = 0;
   int          n_fail = 0;

   ysyx_25020037_axi_master_if axi();

   ysyx_25020037_axi_master #(.AXI_ID(4'h0), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
      .i_req_addr(req_addr), .i_req_size(req_size), .i_req_wdata(req_wdata), .i_req_wstrb(req_wstrb),
      .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
      .axi(axi)
   );

   // free-running clock
   always #5 clk = ~clk;

   // hard stop in case the flow ever stalls
   initial begin
      #300000;
      $display("FAIL global_timeout observed=stall expected=finish");
      $fatal(1, "bench stalled");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // hold the response for hd cycles, then accept it and confirm the bridge is free again
   task automatic finish_resp(input logic [31:0] ed, input logic ee, input int hd);
      for (int h = 0; h <= hd; h++) begin
         chk("resp_valid", resp_valid, 1);
         chk("resp_rdata", resp_rdata, ed);
         chk("resp_err", resp_err, ee);
         chk("req_ready_in_resp", req_ready, 0);
         chk("no_ready_in_resp", {axi.rready, axi.bready, axi.arvalid, axi.awvalid, axi.wvalid}, 0);
         resp_ready = (h == hd);
         tick();
      end
      resp_ready = 1'b0;
      chk("resp_done", resp_valid, 0);
      chk("req_ready_back", req_ready, 1);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] word,
                          input logic [1:0] rr, input logic [3:0] id, input logic rl,
                          input int ad, input int rd, input int hd);
      logic [31:0] ed;
      logic        ee;
      ed = word >> (8 * int'(a[1:0]));
      ee = (rr != 2'b00) || (id != 4'h0) || !rl;
      chk("rd_req_ready", req_ready, 1);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_size = sz;
      tick();
      req_valid = 1'b0; req_addr = 32'h0; req_size = 3'd0;
      axi.rvalid = 1'b1; axi.rdata = 32'hFFFF_FFFF; axi.rresp = 2'b11; axi.rid = 4'hF; axi.rlast = 1'b0;
      chk("arsize", axi.arsize, sz);
      chk("arlen_burst_id", {axi.arlen, axi.arburst, axi.arid}, {8'd0, 2'b01, 4'h0});
      for (int c = 0; c <= ad; c++) begin
         chk("arvalid", axi.arvalid, 1);
         chk("araddr", axi.araddr, a);
         chk("rready_early", axi.rready, 0);
         chk("req_ready_busy", req_ready, 0);
         axi.arready = (c == ad);
         tick();
      end
      axi.arready = 1'b0; axi.rvalid = 1'b0;
      for (int c = 0; c <= rd; c++) begin
         chk("arvalid_drop", axi.arvalid, 0);
         chk("rready", axi.rready, 1);
         chk("resp_early", resp_valid, 0);
         if (c == rd) begin
            axi.rvalid = 1'b1; axi.rdata = word; axi.rresp = rr; axi.rid = id; axi.rlast = rl;
         end
         tick();
      end
      axi.rvalid = 1'b0;
      finish_resp(ed, ee, hd);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd, input logic [3:0] ws,
                           input logic [1:0] br, input logic [3:0] id,
                           input int awd, input int wdl, input int bd, input int hd);
      logic [31:0] ew;
      logic [3:0]  es;
      int          off;
      int          m;
      off = int'(a[1:0]);
      ew = 32'd0; es = 4'd0;
      for (int b = 0; b < 4; b++) if (b >= off) begin
         ew[8*b +: 8] = wd[8*(b-off) +: 8];
         es[b] = ws[b-off];
      end
      m = (awd > wdl) ? awd : wdl;
      chk("wr_req_ready", req_ready, 1);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_size = sz; req_wdata = wd; req_wstrb = ws;
      tick();
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_wstrb = 4'h0;
      axi.bvalid = 1'b1; axi.bresp = 2'b11; axi.bid = 4'hF;
      chk("awsize", axi.awsize, sz);
      chk("aw_fixed", {axi.awlen, axi.awburst, axi.awid}, {8'd0, 2'b01, 4'h0});
      chk("arvalid_on_write", axi.arvalid, 0);
      for (int c = 0; c <= m; c++) begin
         chk("awvalid", axi.awvalid, (c <= awd));
         chk("wvalid", axi.wvalid, (c <= wdl));
         chk("bready_early", axi.bready, 0);
         if (c <= awd) chk("awaddr", axi.awaddr, a);
         if (c <= wdl) begin
            chk("wdata", axi.wdata, ew);
            chk("wstrb", axi.wstrb, es);
            chk("wlast", axi.wlast, 1);
         end
         axi.awready = (c == awd);
         axi.wready = (c == wdl);
         tick();
      end
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
      for (int c = 0; c <= bd; c++) begin
         chk("bready", axi.bready, 1);
         chk("aw_w_dropped", {axi.awvalid, axi.wvalid}, 0);
         chk("resp_early_wr", resp_valid, 0);
         if (c == bd) begin
            axi.bvalid = 1'b1; axi.bresp = br; axi.bid = id;
         end
         tick();
      end
      axi.bvalid = 1'b0;
      finish_resp(32'd0, (br != 2'b00) || (id != 4'h0), hd);
   endtask

   // linear directed sequence followed by randomized transactions
   initial begin
      logic        we;
      logic [2:0]  sz;
      logic [31:0] a;
      logic [1:0]  lo;
      logic [1:0]  rr;
      logic [3:0]  id;
      axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = 4'h0;
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00; axi.rdata = 32'h0; axi.rlast = 1'b0; axi.rid = 4'h0;
      tick();
      tick();
      chk("rst_valids", {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready}, 0);
      chk("rst_resp", {resp_valid, resp_err}, 0);
      chk("rst_rdata", resp_rdata, 0);
      chk("rst_payload", axi.araddr | axi.wdata | {28'd0, axi.wstrb}, 0);
      rst = 1'b0;
      chk("rst_req_ready", req_ready, 1);

      do_read(32'h8000_0000, 3'd2, 32'h1234_5678, 2'b00, 4'h0, 1'b1, 2, 0, 0);
      do_read(32'h8000_0003, 3'd0, 32'hAB00_0000, 2'b00, 4'h0, 1'b1, 0, 0, 1);
      do_write(32'h8000_0002, 3'd1, 32'h0000_BEEF, 4'b0011, 2'b00, 4'h0, 0, 0, 0, 0);
      do_write(32'h8000_0010, 3'd2, 32'hCAFE_F00D, 4'b1111, 2'b00, 4'h0, 1, 4, 1, 0);
      do_write(32'h8000_0020, 3'd2, 32'h0102_0304, 4'b1111, 2'b00, 4'h0, 3, 0, 0, 2);
      do_read(32'h8000_0004, 3'd2, 32'h5555_AAAA, 2'b10, 4'h0, 1'b1, 0, 1, 0);
      do_write(32'h8000_0008, 3'd2, 32'h1111_2222, 4'b1111, 2'b00, 4'h5, 0, 0, 2, 0);
      do_read(32'h8000_0001, 3'd0, 32'h00C3_0000, 2'b00, 4'h0, 1'b0, 1, 0, 0);
      do_read(32'h8000_0002, 3'd1, 32'h9876_0000, 2'b00, 4'h3, 1'b1, 0, 0, 0);

      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0040; req_size = 3'd2;
      tick();
      req_valid = 1'b0;
      chk("mid_arvalid", axi.arvalid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_arvalid", axi.arvalid, 0);
      chk("mid_rst_idle", req_ready, 1);
      chk("mid_rst_noresp", resp_valid, 0);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_0044; req_wdata = 32'h77; req_wstrb = 4'h1;
      tick();
      req_valid = 1'b0; req_we = 1'b0;
      chk("mid_awvalid", {axi.awvalid, axi.wvalid}, 2'b11);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_aw_w", {axi.awvalid, axi.wvalid, axi.bready}, 0);
      tick();
      chk("mid_rst_noresp2", resp_valid, 0);
      chk("mid_rst_idle2", req_ready, 1);

      for (int i = 0; i < 40; i++) begin
         we = 1'($urandom_range(0, 1));
         sz = 3'($urandom_range(0, 2));
         lo = 2'($urandom_range(0, 3));
         lo = (sz == 3'd2) ? 2'd0 : (sz == 3'd1) ? {lo[1], 1'b0} : lo;
         a = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | {30'd0, lo};
         rr = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         id = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         if (we)
            do_write(a, sz, $urandom, 4'($urandom_range(0, 15)), rr, id,
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
         else
            do_read(a, sz, $urandom, rr, id, ($urandom_range(0, 7) != 0),
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

`ifdef YSYX_25020037_AXI_TIMEOUT_EN
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h8000_0000; req_size = 3'd2;
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < 16; c++) begin
         chk("to_wait_resp", resp_valid, 0);
         chk("to_wait_arvalid", axi.arvalid, 1);
         tick();
      end
      chk("to_resp_valid", resp_valid, 1);
      chk("to_rdata", resp_rdata, 32'hDEAD_BEEF);
      chk("to_err", resp_err, 1);
      chk("to_arvalid", axi.arvalid, 0);
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("to_idle", req_ready, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/ysyx_25020037_axi_master.md
# ysyx_25020037_axi_master

Single-outstanding AXI4 master bridge between the core's simple load/store request port and the AXI4 memory fabric. It initiator-drives the single-beat transactions that the AXI4 SRAM and other fabric responders answer. It converts one request into one AR/R or AW/W/B transaction, handles byte-lane alignment, and returns one response to the core.

## Interface
Parameters:
- AXI_ID, 4'h0, value driven on arid/awid and expected on rid/bid
- TIMEOUT_CYCLES, 1024, watchdog limit, used only with YSYX_25020037_AXI_TIMEOUT_EN

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset; one clock; synchronous, active-high
- req_valid  in  1  core request valid
- req_ready  out  1  request accepted when valid&ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  32  byte address
- req_size  in  3  log2 bytes (0/1/2)
- req_wdata  in  32  right-aligned write data
- req_wstrb  in  4  right-aligned byte mask
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_rdata  out  32  right-aligned read data
- resp_err  out  1  error flag
- AXI write channels: awvalid out 1, awready in 1, awaddr out 32, awid out 4, awlen out 8, awsize out 3, awburst out 2; wvalid out 1, wready in 1, wdata out 32, wstrb out 4, wlast out 1; bvalid in 1, bready out 1, bresp in 2, bid in 4
- AXI read channels: arvalid out 1, arready in 1, araddr out 32, arid out 4, arlen out 8, arsize out 3, arburst out 2; rvalid in 1, rready out 1, rresp in 2, rdata in 32, rlast in 1, rid in 4

## Operation
- States: IDLE, RADDR, RDATA, WREQ, WRESP, RESP.
- IDLE: req_ready=1 only here. On req_valid, latch addr/size/we/wdata/wstrb. Go to RADDR if we=0, else WREQ.
- RADDR: arvalid=1 with araddr=latched addr. On arready, go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata>>(8*addr[1:0]). Set err if rresp!=0, rid!=AXI_ID, or rlast=0. Go to RESP.
- WREQ: awvalid and wvalid are raised together. Each drops independently on its own ready; completion is tracked by aw_done/w_done flags. Go to WRESP once both are done, including the cycle where the last ready arrives. wdata=req_wdata<<(8*addr[1:0]); wstrb=(req_wstrb<<addr[1:0])[3:0].
- WRESP: bready=1. On bvalid, err=(bresp!=0)|(bid!=AXI_ID). Go to RESP.
- RESP: resp_valid=1 holding rdata/err. On resp_ready, go to IDLE.
- Fixed fields: ar/awlen=0, ar/awburst=2'b01 (INCR), ar/awsize=req_size, wlast=1, ar/awid=AXI_ID.
- Only one transaction is outstanding at a time; a new request is not accepted until RESP completes.
- Payload outputs (addresses, data, strobes) are held stable while the corresponding valid is high.
- For writes, resp_rdata=0.

## Timing
- Reset: state=IDLE, all AXI valid/ready outputs 0, resp_valid=0, resp_err=0, resp_rdata=0, payload registers 0. req_ready=1 the first cycle after reset deasserts.
- Reset asserted mid-transaction: abandon the transaction and return to IDLE next cycle with all valids 0. No response is issued.
- Valid/ready outputs are registered from state, with no combinational path from AXI inputs to AXI outputs.
- Minimum read latency, with zero-wait responder: request accepted in cycle 0, arvalid in 1, rvalid sampled in 2, resp_valid in 3.
- Minimum write latency: the same, with aw/w in cycle 1, B in 2, resp in 3.
- Responder inputs on R/B outside RDATA/WRESP are ignored.

## Configuration
- YSYX_25020037_AXI_TIMEOUT_EN defined:
  - A 16-bit counter clears on leaving IDLE and increments in RADDR/RDATA/WREQ/WRESP.
  - On reaching TIMEOUT_CYCLES, all AXI valid/ready outputs drop, and the block moves to RESP with resp_err=1 and resp_rdata=32'hDEAD_BEEF.
  - A `$display` message reports the address.
- Undefined: no counter; the block waits indefinitely in any state.

## Test plan
- Read word at 0x80000000, responder returns rdata=0x12345678 after 2-cycle arready delay -> araddr=0x80000000, arsize=2, resp_rdata=0x12345678, resp_err=0.
- Read byte at 0x80000003, rdata=0xAB000000 -> resp_rdata=0x000000AB.
- Write halfword 0xBEEF, wstrb=4'b0011 at 0x80000002 -> wdata=0xBEEF0000, wstrb=4'b1100, wlast=1, resp_valid with err=0.
- Write with awready at cycle+1 and wready at cycle+4 -> awvalid drops after its handshake, wvalid stays high until cycle+4, bready only afterwards, exactly one response.
- Read with rresp=2'b10, then write with bid=4'h5 -> resp_err=1 in both cases.
- With YSYX_25020037_AXI_TIMEOUT_EN and TIMEOUT_CYCLES=16, arready held 0 -> resp_valid at 16 cycles after arvalid rises, resp_err=1, resp_rdata=0xDEADBEEF, arvalid=0.
